serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller that sequences a single full-adder slice, built from two `half_adder` instances, across a WIDTH-bit operand pair, one bit per clock, LSB first. It captures operands on a start request, runs the carry chain through a carry register, and presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It is the area-minimal alternative to a ripple array and sits between a requesting unit and the shared 1-bit adder datapath.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 1..32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state immediately.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  operand A; captured on the accepting edge.
- `b`  in  WIDTH  operand B; captured on the accepting edge.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; high in DONE only.
- `sum`  out  WIDTH  result; valid from DONE until the next accepted start.
- `cout`  out  1  carry out of bit WIDTH-1; same validity as `sum`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when `start`=1. The same edge loads shift registers from `a`/`b`, clears the carry register, and clears the bit counter to 0.
  - RUN→RUN while counter < WIDTH-1.
  - RUN→DONE on the edge that processes bit WIDTH-1.
  - DONE→IDLE unconditionally.
- Slice per RUN cycle:
  - HA1 = (a_sr[0], b_sr[0]).
  - HA2 = (HA1.sum, carry).
  - s = HA2.sum.
  - c_next = HA1.cout | HA2.cout.
- RUN edge actions:
  - s shifts into the MSB of the result register; the result register shifts right.
  - a_sr and b_sr shift right.
  - carry ← c_next; counter increments.
  - After WIDTH shifts, bit i of the result register holds sum bit i.
- `cout` loads c_next on the RUN→DONE edge.
- `sum` and `cout` hold their values through IDLE until the next accepting edge. On that edge `cout` clears to 0; the result register is then overwritten progressively.
- `start` in RUN or DONE is ignored; no queuing.
- Arithmetic: unsigned modulo 2^WIDTH; overflow is reported only via `cout`.
- Counter width: $clog2(WIDTH)+1 bits. The counter must not wrap before the DONE transition for any legal WIDTH, including WIDTH=1 and WIDTH=32.
- Operand inputs are don't-care except on the accepting edge.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0. State = IDLE; carry, counter and shift registers = 0.
- `rst` asserted mid-operation aborts the operation; the result is lost and no `done` is produced. The first legal start is on the first edge with `rst` low.
- Cycle timeline, with E0 = the accepting edge:
  - `busy` rises after E0.
  - Bit i is computed at edge E(i+1).
  - `done`=1 and `sum`/`cout` are valid after E(WIDTH).
  - `done` and `busy` fall after E(WIDTH+1).
- Latency from accepting edge to `done`: WIDTH cycles.
- Minimum start-to-start period: WIDTH+2 cycles. With `start` held high, operations repeat at exactly this period.
- There is no combinational path from inputs to outputs.

## Structure
- Shared package `serial_adder_pkg`:
  - state enum or localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default WIDTH constant.
- Sub-module: two instances of the existing `half_adder`, forming the 1-bit slice. All other logic is inline in the controller.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start for 1 cycle -> `done` 8 cycles after the accepting edge; sum=0x96, cout=0; `busy` high for 9 cycles.
- a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0x00, b=0x00 -> sum=0x00, cout=0, with cout cleared on the accepting edge.
- Accept a=0x10, b=0x20; pulse `start` with a=0xFF, b=0xFF in RUN cycle 3 and again in DONE -> result 0x30, cout=0; no second operation.
- Assert `rst` in RUN cycle 4 of a=0xAA, b=0x55 -> all outputs 0 immediately, no `done`. Then a=0x01, b=0x02 -> sum=0x03.
- `start` held high for 30 cycles -> `done` pulses every 10 cycles; every result matches the operands sampled on its accepting edge.
- WIDTH=1: a=1, b=1 -> `done` 1 cycle after accept, sum=0, cout=1. WIDTH=32: a=0xFFFFFFFF, b=1 -> sum=0, cout=1 at 32 cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_ctrl_half_adder.sv
// Single-bit half adder; two of these form the serial full-adder slice.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences one full-adder slice over a WIDTH-bit
// operand pair, LSB first, and reports sum/carry-out with a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra counter bit so the count never wraps before DONE, even at WIDTH=1.
  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t            state, nxt;
  logic [WIDTH-1:0]  a_sr, b_sr, res_q, res_nxt;
  logic [CW-1:0]     cnt;
  logic              carry, cout_q;
  logic              ha1_s, ha1_c, ha2_s, ha2_c, c_next;

  half_adder u_ha1 (.a(a_sr[0]), .b(b_sr[0]), .s(ha1_s), .c(ha1_c));
  half_adder u_ha2 (.a(ha1_s),   .b(carry),   .s(ha2_s), .c(ha2_c));

  assign c_next = ha1_c | ha2_c;

  // The new bit enters at the MSB so that after WIDTH shifts bit i sits at index i.
  if (WIDTH == 1) begin : g_res_w1
    assign res_nxt = ha2_s;
  end else begin : g_res_wn
    assign res_nxt = {ha2_s, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (cnt == LAST) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_q  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr   <= a;
          b_sr   <= b;
          carry  <= 1'b0;
          cnt    <= '0;
          cout_q <= 1'b0;
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          res_q <= res_nxt;
          carry <= c_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) cout_q <= c_next;
        end
        default: ;
      endcase
    end
  end

  assign sum  = res_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized bench for serial_adder_ctrl at WIDTH = 8, 1 and 32.
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  int          sel = 8;

  logic        busy8, done8, cout8, busy1, done1, cout1, busy32, done32, cout32;
  logic [7:0]  sum8;
  logic [0:0]  sum1;
  logic [31:0] sum32;
  logic        obs_busy, obs_done, obs_cout;
  logic [31:0] obs_sum;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start && (sel == 8)), .a(a[7:0]), .b(b[7:0]),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start && (sel == 1)), .a(a[0:0]), .b(b[0:0]),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  serial_adder_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start && (sel == 32)), .a(a), .b(b),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32));

  always_comb begin
    case (sel)
      1:       begin obs_busy = busy1;  obs_done = done1;  obs_cout = cout1;  obs_sum = {31'd0, sum1}; end
      32:      begin obs_busy = busy32; obs_done = done32; obs_cout = cout32; obs_sum = sum32;         end
      default: begin obs_busy = busy8;  obs_done = done8;  obs_cout = cout8;  obs_sum = {24'd0, sum8}; end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned add of the w-bit operands; sum = low w bits, cout = bit w.
  task automatic ref_add(input int w, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] es, output logic ec);
    logic [63:0] m, full;
    m    = (64'd1 << w) - 64'd1;
    full = ({32'd0, av} & m) + ({32'd0, bv} & m);
    es   = 32'(full & m);
    ec   = full[w];
  endtask

  // One full operation from the accepting edge; glitch bit k drives start=1
  // (with junk operands) in the cycle following edge k.
  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] glitch);
    logic [31:0] es;
    logic        ec;
    ref_add(w, av, bv, es, ec);
    sel = w; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    chk("busy_after_accept", obs_busy, 1);
    chk("done_after_accept", obs_done, 0);
    chk("cout_cleared_on_accept", obs_cout, 0);
    for (int k = 1; k <= w + 1; k++) begin
      @(posedge clk); #1;
      if (k < w) begin
        chk("busy_run", obs_busy, 1);
        chk("done_run", obs_done, 0);
      end else if (k == w) begin
        chk("busy_done", obs_busy, 1);
        chk("done_pulse", obs_done, 1);
        chk("sum", obs_sum, es);
        chk("cout", obs_cout, ec);
      end else begin
        chk("busy_fall", obs_busy, 0);
        chk("done_fall", obs_done, 0);
        chk("sum_hold", obs_sum, es);
        chk("cout_hold", obs_cout, ec);
      end
      start = glitch[k];
      if (glitch[k]) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_second_op", obs_busy, 0);
  endtask

  logic [31:0] ops_a [30];
  logic [31:0] ops_b [30];
  logic [31:0] es_h;
  logic        ec_h;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", obs_busy, 0);
    chk("rst_done", obs_done, 0);
    chk("rst_sum", obs_sum, 0);
    chk("rst_cout", obs_cout, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8, 32'h5A, 32'h3C, 64'd0);
    run_op(8, 32'hFF, 32'h01, 64'd0);
    run_op(8, 32'h00, 32'h00, 64'd0);
    run_op(8, 32'h10, 32'h20, (64'd1 << 3) | (64'd1 << 8));
    for (int i = 0; i < 4; i++) run_op(8, $urandom, $urandom, 64'd0);

    // Abort mid-operation with an asynchronous reset.
    sel = 8; a = 32'hAA; b = 32'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", obs_busy, 0);
    chk("abort_done", obs_done, 0);
    chk("abort_sum", obs_sum, 0);
    chk("abort_cout", obs_cout, 0);
    @(posedge clk); #1;
    chk("abort_no_done", obs_done, 0);
    rst = 1'b0;
    run_op(8, 32'h01, 32'h02, 64'd0);

    // start held high: accepts every WIDTH+2 = 10 cycles.
    sel = 8;
    for (int j = 0; j < 30; j++) begin
      a = $urandom; b = $urandom; start = 1'b1;
      ops_a[j] = a; ops_b[j] = b;
      @(posedge clk); #1;
      chk("held_busy", obs_busy, (j % 10) != 9);
      chk("held_done", obs_done, (j % 10) == 8);
      if ((j % 10) == 8) begin
        ref_add(8, ops_a[j-8], ops_b[j-8], es_h, ec_h);
        chk("held_sum", obs_sum, es_h);
        chk("held_cout", obs_cout, ec_h);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("held_idle", obs_busy, 0);

    run_op(1, 32'h1, 32'h1, 64'd0);
    run_op(1, 32'h1, 32'h0, 64'd0);
    run_op(32, 32'hFFFF_FFFF, 32'h1, 64'd0);
    run_op(32, $urandom, $urandom, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
